// File: rtl/ball_physics_engine.sv
// Single-ball engine: serve/live/score sequencing, goal and obstacle detection, wall reflection,
// and one move per movement tick.
module ball_physics_engine #(
    parameter int NUM_OBSTACLES   = 4,
    parameter int POS_W           = 11,
    parameter int BALL_RADIUS     = 8,
    parameter int OBSTACLE_RADIUS = 20,
    parameter int GOAL_RADIUS     = 30,
    parameter int TICK_DIV        = 28,
    parameter int SERVE_DELAY     = 60,
    parameter int INIT_SPEED      = 2,
    parameter int MAX_SPEED       = 6,
    parameter int FIELD_X_MIN     = 150,
    parameter int FIELD_X_MAX     = 660,
    parameter int FIELD_Y_MIN     = 36,
    parameter int FIELD_Y_MAX     = 510,
    parameter int SPAWN_X         = 400,
    parameter int SPAWN_Y         = 275,
    parameter int GOAL_A_X        = 400,
    parameter int GOAL_A_Y        = 430,
    parameter int GOAL_B_X        = 400,
    parameter int GOAL_B_Y        = 120
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  game_initiated,
    input  logic                                                  game_over,
    input  logic [NUM_OBSTACLES*10-1:0]                           obstacle_x,
    input  logic [NUM_OBSTACLES*10-1:0]                           obstacle_y,
    output logic signed [POS_W-1:0]                               x_position,
    output logic signed [POS_W-1:0]                               y_position,
    output logic                                                  ball_live,
    output logic                                                  score_a_pulse,
    output logic                                                  score_b_pulse,
    output logic [(NUM_OBSTACLES > 1 ? $clog2(NUM_OBSTACLES) : 1)-1:0] last_hit_idx
);

    localparam int IdxW = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1;
    localparam int CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SrvW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int DW   = POS_W + 1;
    localparam int SqW  = 2 * DW;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StServe  = 2'd1;
    localparam logic [1:0] StLive   = 2'd2;
    localparam logic [1:0] StScored = 2'd3;

    localparam logic [SqW:0] HitR2  = (SqW+1)'((OBSTACLE_RADIUS + BALL_RADIUS) *
                                               (OBSTACLE_RADIUS + BALL_RADIUS));
    localparam logic [SqW:0] GoalR2 = (SqW+1)'((GOAL_RADIUS - BALL_RADIUS) *
                                               (GOAL_RADIUS - BALL_RADIUS));

    localparam logic signed [POS_W-1:0] SpawnX = POS_W'(SPAWN_X);
    localparam logic signed [POS_W-1:0] SpawnY = POS_W'(SPAWN_Y);
    localparam logic signed [POS_W-1:0] XLo    = POS_W'(FIELD_X_MIN + BALL_RADIUS);
    localparam logic signed [POS_W-1:0] XHi    = POS_W'(FIELD_X_MAX - BALL_RADIUS);
    localparam logic signed [POS_W-1:0] YLo    = POS_W'(FIELD_Y_MIN + BALL_RADIUS);
    localparam logic signed [POS_W-1:0] YHi    = POS_W'(FIELD_Y_MAX - BALL_RADIUS);
    localparam logic signed [DW-1:0]    GoalAX = DW'(GOAL_A_X);
    localparam logic signed [DW-1:0]    GoalAY = DW'(GOAL_A_Y);
    localparam logic signed [DW-1:0]    GoalBX = DW'(GOAL_B_X);
    localparam logic signed [DW-1:0]    GoalBY = DW'(GOAL_B_Y);
    localparam logic signed [4:0]       InitSpd = 5'(INIT_SPEED);
    localparam logic [4:0]              MaxSpd  = 5'(MAX_SPEED);

    function automatic logic [SqW-1:0] square(input logic signed [DW-1:0] d);
        logic signed [SqW-1:0] e;
        e = SqW'(d);
        return $unsigned(e * e);
    endfunction

    function automatic logic [SqW:0] dist2(input logic signed [DW-1:0] a,
                                           input logic signed [DW-1:0] b);
        return {1'b0, square(a)} + {1'b0, square(b)};
    endfunction

    function automatic logic signed [4:0] abs5(input logic signed [4:0] v);
        return v[4] ? -v : v;
    endfunction

    // Grow the magnitude by one up to the cap while keeping the sign.
    function automatic logic signed [4:0] speed_up(input logic signed [4:0] v);
        logic [4:0] mag;
        mag = v[4] ? 5'(-v) : 5'(v);
        mag = (mag >= MaxSpd) ? MaxSpd : mag + 5'd1;
        return v[4] ? -$signed(mag) : $signed(mag);
    endfunction

    logic [1:0]              state_q, state_d;
    logic [CntW-1:0]         tick_cnt_q;
    logic [SrvW-1:0]         serve_q, serve_d;
    logic signed [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic signed [4:0]       vx_q, vx_d, vy_q, vy_d;
    logic [IdxW-1:0]         hit_q, hit_d;
    logic                    sa_q, sa_d, sb_q, sb_d;
    logic                    tick;

    logic signed [DW-1:0]    bx, by;
    logic signed [DW-1:0]    obs_dx [NUM_OBSTACLES];
    logic signed [DW-1:0]    obs_dy [NUM_OBSTACLES];
    logic [NUM_OBSTACLES-1:0] obs_in;
    logic                    hit_any;
    logic [IdxW-1:0]         hit_idx;
    logic signed [DW-1:0]    hit_dx, hit_dy;
    logic [DW-1:0]           adx, ady;
    logic                    goal_a_in, goal_b_in;
    logic signed [4:0]       refl_vx, refl_vy, wall_vx, wall_vy, new_vx, new_vy;
    logic signed [POS_W-1:0] wall_x, wall_y, base_x, base_y;

    assign tick = (tick_cnt_q == CntW'(TICK_DIV - 1));
    assign bx   = DW'(x_q);
    assign by   = DW'(y_q);

    assign goal_a_in = dist2(bx - GoalAX, by - GoalAY) < GoalR2;
    assign goal_b_in = dist2(bx - GoalBX, by - GoalBY) < GoalR2;

    always_comb begin
        for (int i = 0; i < NUM_OBSTACLES; i++) begin
            obs_dx[i] = bx - $signed({{(DW-10){1'b0}}, obstacle_x[10*i +: 10]});
            obs_dy[i] = by - $signed({{(DW-10){1'b0}}, obstacle_y[10*i +: 10]});
            obs_in[i] = dist2(obs_dx[i], obs_dy[i]) < HitR2;
        end
    end

    // Scan from the top so the lowest qualifying index wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        hit_dx  = '0;
        hit_dy  = '0;
        for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
            if (obs_in[i]) begin
                hit_any = 1'b1;
                hit_idx = IdxW'(i);
                hit_dx  = obs_dx[i];
                hit_dy  = obs_dy[i];
            end
        end
    end

    always_comb begin
        adx     = hit_dx[DW-1] ? -hit_dx : hit_dx;
        ady     = hit_dy[DW-1] ? -hit_dy : hit_dy;
        refl_vx = speed_up((adx >= ady) ? -vx_q : vx_q);
        refl_vy = speed_up((ady >= adx) ? -vy_q : vy_q);
    end

    always_comb begin
        wall_x  = x_q;
        wall_y  = y_q;
        wall_vx = vx_q;
        wall_vy = vy_q;
        if (x_q < XLo) begin
            wall_x  = XLo;
            wall_vx = abs5(vx_q);
        end else if (x_q > XHi) begin
            wall_x  = XHi;
            wall_vx = -abs5(vx_q);
        end
        if (y_q < YLo) begin
            wall_y  = YLo;
            wall_vy = abs5(vy_q);
        end else if (y_q > YHi) begin
            wall_y  = YHi;
            wall_vy = -abs5(vy_q);
        end
    end

    assign new_vx = hit_any ? refl_vx : wall_vx;
    assign new_vy = hit_any ? refl_vy : wall_vy;
    assign base_x = hit_any ? x_q : wall_x;
    assign base_y = hit_any ? y_q : wall_y;

    always_comb begin
        state_d = state_q;
        serve_d = serve_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        hit_d   = hit_q;
        sa_d    = 1'b0;
        sb_d    = 1'b0;
        if (game_over) begin
            state_d = StIdle;
            x_d     = SpawnX;
            y_d     = SpawnY;
            vx_d    = InitSpd;
            vy_d    = InitSpd;
        end else begin
            case (state_q)
                StIdle: begin
                    x_d = SpawnX;
                    y_d = SpawnY;
                    if (game_initiated) begin
                        state_d = StServe;
                        serve_d = '0;
                    end
                end
                StServe: begin
                    x_d = SpawnX;
                    y_d = SpawnY;
                    if (tick) begin
                        if (serve_q == SrvW'(SERVE_DELAY - 1)) state_d = StLive;
                        else                                   serve_d = serve_q + SrvW'(1);
                    end
                end
                StLive: begin
                    if (tick) begin
                        if (goal_b_in || goal_a_in) begin
                            state_d = StScored;
                            x_d     = SpawnX;
                            y_d     = SpawnY;
                            vx_d    = InitSpd;
                            vy_d    = goal_b_in ? InitSpd : -InitSpd;
                            sa_d    = goal_b_in;
                            sb_d    = !goal_b_in;
                        end else begin
                            x_d  = base_x + POS_W'(new_vx);
                            y_d  = base_y + POS_W'(new_vy);
                            vx_d = new_vx;
                            vy_d = new_vy;
                            if (hit_any) hit_d = hit_idx;
                        end
                    end
                end
                StScored: begin
                    x_d     = SpawnX;
                    y_d     = SpawnY;
                    state_d = StServe;
                    serve_d = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            serve_q    <= '0;
            x_q        <= SpawnX;
            y_q        <= SpawnY;
            vx_q       <= InitSpd;
            vy_q       <= InitSpd;
            hit_q      <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CntW'(1);
            serve_q    <= serve_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            hit_q      <= hit_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
        end
    end

    assign x_position    = x_q;
    assign y_position    = y_q;
    assign ball_live     = (state_q == StLive);
    assign score_a_pulse = sa_q;
    assign score_b_pulse = sb_q;
    assign last_hit_idx  = hit_q;

endmodule

// File: tb/tb_ball_physics_engine.sv
// Bench for ball_physics_engine: directed serve/hit/goal scenarios plus randomized play
// checked every cycle against a tick-level arithmetic model of the ball.
module tb_ball_physics_engine;

    localparam int TD = 4;
    localparam int SD = 2;
    localparam int NO = 4;

    localparam int PH_IDLE = 0, PH_SERVE = 1, PH_LIVE = 2, PH_SCORED = 3;

    logic clk = 1'b0;
    logic rst, game_initiated, game_over;
    logic [NO*10-1:0] obstacle_x, obstacle_y;

    logic signed [10:0] x_m, y_m, x_gb, y_gb, x_ga, y_ga;
    logic live_m, sa_m, sb_m, live_gb, sa_gb, sb_gb, live_ga, sa_ga, sb_ga;
    logic [1:0] hit_m, hit_gb, hit_ga;

    always #5 clk = ~clk;

    ball_physics_engine #(.TICK_DIV(TD), .SERVE_DELAY(SD)) dut (
        .clk(clk), .rst(rst), .game_initiated(game_initiated), .game_over(game_over),
        .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
        .x_position(x_m), .y_position(y_m), .ball_live(live_m),
        .score_a_pulse(sa_m), .score_b_pulse(sb_m), .last_hit_idx(hit_m)
    );

    ball_physics_engine #(.TICK_DIV(TD), .SERVE_DELAY(SD), .GOAL_B_Y(285)) dut_gb (
        .clk(clk), .rst(rst), .game_initiated(game_initiated), .game_over(game_over),
        .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
        .x_position(x_gb), .y_position(y_gb), .ball_live(live_gb),
        .score_a_pulse(sa_gb), .score_b_pulse(sb_gb), .last_hit_idx(hit_gb)
    );

    ball_physics_engine #(.TICK_DIV(TD), .SERVE_DELAY(SD), .GOAL_A_X(420), .GOAL_A_Y(295))
    dut_ga (
        .clk(clk), .rst(rst), .game_initiated(game_initiated), .game_over(game_over),
        .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
        .x_position(x_ga), .y_position(y_ga), .ball_live(live_ga),
        .score_a_pulse(sa_ga), .score_b_pulse(sb_ga), .last_hit_idx(hit_ga)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model of the main instance (default field and goals).
    bit m_valid = 1'b0;
    int m_phase, m_cnt, m_serve, m_x, m_y, m_vx, m_vy, m_hit, m_sa, m_sb;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int faster(input int v);
        int mag;
        mag = iabs(v) + 1;
        if (mag > 6) mag = 6;
        return (v < 0) ? -mag : mag;
    endfunction

    function automatic bit in_circle(input int x, input int y, input int cx, input int cy,
                                     input int r);
        return ((x - cx) * (x - cx) + (y - cy) * (y - cy)) < r * r;
    endfunction

    task automatic spawn_model();
        m_x = 400;
        m_y = 275;
    endtask

    task automatic live_tick();
        int x, y, best, bdx, bdy, dx, dy;
        x    = m_x;
        y    = m_y;
        best = -1;
        bdx  = 0;
        bdy  = 0;
        if (in_circle(x, y, 400, 120, 22)) begin
            m_sa = 1; m_phase = PH_SCORED; spawn_model(); m_vx = 2; m_vy = 2;
        end else if (in_circle(x, y, 400, 430, 22)) begin
            m_sb = 1; m_phase = PH_SCORED; spawn_model(); m_vx = 2; m_vy = -2;
        end else begin
            for (int i = 0; i < NO; i++) begin
                dx = x - int'(obstacle_x[10*i +: 10]);
                dy = y - int'(obstacle_y[10*i +: 10]);
                if (best < 0 && dx * dx + dy * dy < 28 * 28) begin
                    best = i; bdx = dx; bdy = dy;
                end
            end
            if (best >= 0) begin
                if (iabs(bdx) >= iabs(bdy)) m_vx = -m_vx;
                if (iabs(bdy) >= iabs(bdx)) m_vy = -m_vy;
                m_vx  = faster(m_vx);
                m_vy  = faster(m_vy);
                m_hit = best;
            end else begin
                if (y < 44)       begin m_vy = iabs(m_vy);  y = 44;  end
                else if (y > 502) begin m_vy = -iabs(m_vy); y = 502; end
                if (x < 158)      begin m_vx = iabs(m_vx);  x = 158; end
                else if (x > 652) begin m_vx = -iabs(m_vx); x = 652; end
            end
            m_x = x + m_vx;
            m_y = y + m_vy;
        end
    endtask

    task automatic model_update();
        bit tick;
        if (rst) begin
            m_valid = 1'b1;
            m_phase = PH_IDLE; m_cnt = 0; m_serve = 0; spawn_model();
            m_vx = 2; m_vy = 2; m_hit = 0; m_sa = 0; m_sb = 0;
            return;
        end
        if (!m_valid) return;
        tick  = (m_cnt == TD - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        m_sa  = 0;
        m_sb  = 0;
        if (game_over) begin
            m_phase = PH_IDLE; spawn_model(); m_vx = 2; m_vy = 2;
        end else begin
            case (m_phase)
                PH_IDLE:  if (game_initiated) begin m_phase = PH_SERVE; m_serve = 0; end
                PH_SERVE: if (tick) begin
                    if (m_serve == SD - 1) m_phase = PH_LIVE;
                    else                   m_serve++;
                end
                PH_LIVE:  if (tick) live_tick();
                default:  begin m_phase = PH_SERVE; m_serve = 0; end
            endcase
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        if (m_valid) begin
            check("x", x_m, m_x);
            check("y", y_m, m_y);
            check("live", live_m, int'(m_phase == PH_LIVE));
            check("score_a", sa_m, m_sa);
            check("score_b", sb_m, m_sb);
            check("last_hit", hit_m, m_hit);
        end
    endtask

    task automatic set_obs(input int i, input int ox, input int oy);
        obstacle_x[10*i +: 10] = 10'(ox);
        obstacle_y[10*i +: 10] = 10'(oy);
    endtask

    task automatic random_obstacles();
        int ox, oy;
        for (int i = 0; i < NO; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                ox = m_x + int'($urandom_range(0, 56)) - 28;
                oy = m_y + int'($urandom_range(0, 56)) - 28;
                if (ox < 0) ox = 0;
                if (oy < 0) oy = 0;
                if (ox > 1023) ox = 1023;
                if (oy > 1023) oy = 1023;
                set_obs(i, ox, oy);
            end else if ($urandom_range(0, 9) == 0) begin
                set_obs(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
        end
    endtask

    initial begin
        rst = 1'b1; game_initiated = 1'b0; game_over = 1'b0;
        obstacle_x = '0; obstacle_y = '0;
        repeat (3) step();
        check("rst_x", x_m, 400);
        check("rst_y", y_m, 275);
        check("rst_live", live_m, 0);
        check("rst_hit", hit_m, 0);

        // Plain serve, goal at spawn (dut_gb), goal reached after moves (dut_ga).
        rst = 1'b0; game_initiated = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            if (k == 48) game_over = 1'b1;
            step();
            if (k == 7)  check("serve_hold_live", live_m, 0);
            if (k == 8)  begin check("live_rise", live_m, 1); check("live_rise_x", x_m, 400); end
            if (k == 12) begin check("mv1_x", x_m, 402); check("mv1_y", y_m, 277); end
            if (k == 16) begin check("mv2_x", x_m, 404); check("mv2_y", y_m, 279); end
            if (k == 11) check("gb_pre", sa_gb, 0);
            if (k == 12) begin
                check("gb_pulse", sa_gb, 1); check("gb_other", sb_gb, 0);
                check("gb_x", x_gb, 400);    check("gb_y", y_gb, 275);
            end
            if (k == 13) begin check("gb_pulse_end", sa_gb, 0); check("gb_serve", live_gb, 0); end
            if (k == 36) check("gb_pulse3", sa_gb, 1);
            if (k == 24) begin check("ga_pulse", sb_ga, 1); check("ga_other", sa_ga, 0); end
            if (k == 25) check("ga_pulse_end", sb_ga, 0);
            if (k == 36) begin check("ga_serve_x", x_ga, 402); check("ga_serve_y", y_ga, 273); end
            if (k == 48) begin
                check("go_no_pulse", sa_gb, 0); check("go_idle", live_gb, 0);
                check("go_x", x_gb, 400);
                game_over = 1'b0;
            end
            if (k == 49) check("go_late_pulse", sa_gb, 0);
        end

        // Obstacle reflection, then two simultaneous overlaps, then reset mid-LIVE.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        set_obs(0, 420, 295);
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 12) begin check("ob_t1_x", x_m, 402); check("ob_t1_y", y_m, 277); end
            if (k == 16) begin
                check("ob_hit_x", x_m, 399); check("ob_hit_y", y_m, 274);
                check("ob_hit_idx", hit_m, 0);
            end
            if (k == 20) begin
                check("ob_nohit_x", x_m, 396); check("ob_nohit_y", y_m, 271);
                set_obs(1, 406, 271);
                set_obs(2, 396, 281);
            end
            if (k == 24) begin
                check("multi_idx", hit_m, 1);
                check("multi_x", x_m, 400); check("multi_y", y_m, 267);
                set_obs(1, 0, 0);
                set_obs(2, 0, 0);
            end
            if (k == 28) begin check("single_refl_x", x_m, 404); check("single_refl_y", y_m, 263); end
        end
        rst = 1'b1;
        step();
        check("rst_live_x", x_m, 400);
        check("rst_live_y", y_m, 275);
        check("rst_live_flag", live_m, 0);
        check("rst_live_hit", hit_m, 0);
        rst = 1'b0;

        // Randomized play.
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 599) == 0);
            game_over      = ($urandom_range(0, 299) == 0);
            game_initiated = ($urandom_range(0, 19) != 0);
            random_obstacles();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
